// File: rtl/mux16_1.sv
// 16-to-1 WIDTH-bit word selector, sel = {s1,s0}; MUX16_1_COMB_OUT_EN selects a combinational output.
// Latency: 1 cycle registered (reset value 0); 0 cycles when MUX16_1_COMB_OUT_EN is defined.
// Backpressure: none, y is a continuously valid word with no handshake.
module mux16_1 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic [WIDTH-1:0] i5,
    input  logic [WIDTH-1:0] i6,
    input  logic [WIDTH-1:0] i7,
    input  logic [WIDTH-1:0] i8,
    input  logic [WIDTH-1:0] i9,
    input  logic [WIDTH-1:0] i10,
    input  logic [WIDTH-1:0] i11,
    input  logic [WIDTH-1:0] i12,
    input  logic [WIDTH-1:0] i13,
    input  logic [WIDTH-1:0] i14,
    input  logic [WIDTH-1:0] i15,
    input  logic [2:0]       s1,
    input  logic             s0,
    output logic [WIDTH-1:0] y
);

    logic [3:0]       sel;
    logic [WIDTH-1:0] sel_dat;

    assign sel = {s1, s0};

    always_comb begin
        sel_dat = '0;
        case (sel)
            4'd0:  sel_dat = i0;
            4'd1:  sel_dat = i1;
            4'd2:  sel_dat = i2;
            4'd3:  sel_dat = i3;
            4'd4:  sel_dat = i4;
            4'd5:  sel_dat = i5;
            4'd6:  sel_dat = i6;
            4'd7:  sel_dat = i7;
            4'd8:  sel_dat = i8;
            4'd9:  sel_dat = i9;
            4'd10: sel_dat = i10;
            4'd11: sel_dat = i11;
            4'd12: sel_dat = i12;
            4'd13: sel_dat = i13;
            4'd14: sel_dat = i14;
            4'd15: sel_dat = i15;
            default: sel_dat = '0;
        endcase
    end

`ifdef MUX16_1_COMB_OUT_EN
    // Clock and reset stay on the port list so both builds drop into the same socket.
    logic unused_clk_rst;
    assign unused_clk_rst = clk & rst_n;
    assign y = sel_dat;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else begin
            y <= sel_dat;
        end
    end
`endif

endmodule

// File: tb/tb_mux16_1.sv
// Directed bench for mux16_1: stimulus pushes expected words, a monitor pops and compares after each edge.
module tb_mux16_1;

    logic       clk;
    logic       rst_n;
    logic [3:0] d [16];
    logic [2:0] s1;
    logic       s0;
    logic [3:0] y;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] exp_q [$];
    string      name_q [$];

    mux16_1 #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i0(d[0]),   .i1(d[1]),   .i2(d[2]),   .i3(d[3]),
        .i4(d[4]),   .i5(d[5]),   .i6(d[6]),   .i7(d[7]),
        .i8(d[8]),   .i9(d[9]),   .i10(d[10]), .i11(d[11]),
        .i12(d[12]), .i13(d[13]), .i14(d[14]), .i15(d[15]),
        .s1(s1), .s0(s0), .y(y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_now(input logic [3:0] exp, input string nm);
        n_checks++;
        if (y !== exp) begin
            n_errors++;
            $display("FAIL %s: y=%b expected %b at %0t", nm, y, exp, $time);
        end
    endtask

    // Drive select between edges and queue the word expected after the next posedge.
    task automatic drive(input logic [3:0] sel, input logic [3:0] exp, input string nm);
        @(negedge clk);
        s1 = sel[3:1];
        s0 = sel[0];
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    task automatic set_sel(input logic [3:0] sel);
        s1 = sel[3:1];
        s0 = sel[0];
    endtask

`ifndef MUX16_1_COMB_OUT_EN
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                check_now(exp_q.pop_front(), name_q.pop_front());
            end
        end
    end
`endif

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, time=%0t expected end before 50000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 16; k++) d[k] = 4'(k);
        s1 = 3'd0;
        s0 = 1'b0;
        rst_n = 1'b1;
`ifdef MUX16_1_COMB_OUT_EN
        for (int k = 0; k < 16; k++) begin
            set_sel(4'(k));
            #10;
            check_now(4'(k), $sformatf("comb_sweep_%0d", k));
        end
        rst_n = 1'b0;
        set_sel(4'd6);
        #10;
        check_now(4'b0110, "comb_in_reset");
`else
        #1;
        rst_n = 1'b0;
        set_sel(4'd9);
        #1;
        check_now(4'b0000, "reset_async_initial");
        // Clocks while held in reset must not load sel=9.
        for (int c = 0; c < 3; c++) drive(4'd9, 4'b0000, "reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(4'b1001);
        name_q.push_back("reset_release");

        for (int k = 0; k < 16; k++) drive(4'(k), 4'(k), $sformatf("sweep_%0d", k));

        drive(4'b1110, 4'b1110, "split_s1_7_s0_0");
        drive(4'b1111, 4'b1111, "split_s1_7_s0_1");
        drive(4'b0001, 4'b0001, "split_s1_0_s0_1");

        drive(4'd5, 4'b0101, "data_sel5");
        @(negedge clk);
        d[5] = 4'b1010;
        exp_q.push_back(4'b1010);
        name_q.push_back("data_i5_change");
        @(negedge clk);
        d[4] = 4'b1111;
        exp_q.push_back(4'b1010);
        name_q.push_back("data_i4_ignored");
        @(negedge clk);
        d[6] = 4'b0000;
        exp_q.push_back(4'b1010);
        name_q.push_back("data_i6_ignored");
        @(negedge clk);
        d[4] = 4'd4;
        d[5] = 4'd5;
        d[6] = 4'd6;
        set_sel(4'd7);
        d[7] = 4'b0011;
        exp_q.push_back(4'b0011);
        name_q.push_back("sel_and_data_together");

        drive(4'd12, 4'b1100, "midrun_sel12");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_now(4'b0000, "midrun_async_clear");
        drive(4'd12, 4'b0000, "midrun_held");
        @(negedge clk);
        rst_n = 1'b1;
        set_sel(4'd3);
        exp_q.push_back(4'b0011);
        name_q.push_back("midrun_release");

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
